// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface bit_serial_add_ctrl_if
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder.sv
// 1-bit full adder shared across the codebase.
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller: shifts operands LSB-first through one full adder,
// one bit per clock, with a start/busy/done handshake.
module bit_serial_add_ctrl
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst_n,
  bit_serial_add_ctrl_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_q, ovf_q;
  logic             fa_s, fa_c;
  logic             accept;
  logic             last_step;

  full_adder u_fa (
    .s   (fa_s),
    .c   (fa_c),
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry)
  );

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = last_step ? ST_DONE : ST_RUN;
      ST_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a_in;
      b_sr   <= bus.b_in;
      carry  <= bus.cin;
      cnt    <= '0;
      sum_sr <= '0;
    end else if (state == ST_RUN) begin
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_c;
      cnt    <= cnt + 1'b1;
      // carry still holds the carry into the MSB on this step
      if (last_step) begin
        cout_q <= fa_c;
        ovf_q  <= fa_c ^ carry;
        sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
      end
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Bench for bit_serial_add_ctrl at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_bit_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst0 = 1'b0, rst1 = 1'b0;
  logic        st0 = 1'b0, st1 = 1'b0;
  logic        c0 = 1'b0, c1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  logic        d0_busy, d0_done, d0_cout, d0_ovf;
  logic [7:0]  d0_sum;

  always #5 clk = ~clk;

  // {ovf, cout, sum} of a+b+c at width w, from plain unsigned and signed arithmetic
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    longint ua, ub, t, half, sa, sb, ss;
    logic [33:0] r;
    ua   = longint'(a);
    ub   = longint'(b);
    t    = ua + ub + longint'(c);
    half = longint'(1) <<< (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    ss   = sa + sb + longint'(c);
    r[31:0] = 32'(t & (2 * half - 1));
    r[32]   = ((t >>> w) & 1) != 0;
    r[33]   = (ss >= half) || (ss < -half);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 8 : 16;

    bit_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    logic        rstn_sel;
    logic [31:0] a_sel, b_sel;

    assign rstn_sel  = (g == 0) ? rst0 : rst1;
    assign a_sel     = (g == 0) ? a0 : a1;
    assign b_sel     = (g == 0) ? b0 : b1;
    assign bus.start = (g == 0) ? st0 : st1;
    assign bus.cin   = (g == 0) ? c0 : c1;
    assign bus.a_in  = a_sel[W-1:0];
    assign bus.b_in  = b_sel[W-1:0];

    bit_serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rstn_sel),
      .bus   (bus)
    );

    if (g == 0) begin : g_tap
      assign d0_busy = bus.busy;
      assign d0_done = bus.done;
      assign d0_cout = bus.cout;
      assign d0_ovf  = bus.ovf;
      assign d0_sum  = bus.sum[7:0];
    end

    // Model: an accepted start yields a result W edges later; idle/done accept starts
    int unsigned m_left;
    logic        m_done, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    logic [33:0] p_res;

    always @(posedge clk or negedge rstn_sel) begin
      if (!rstn_sel) begin
        m_left <= 0;
        m_done <= 1'b0;
        m_sum  <= '0;
        m_cout <= 1'b0;
        m_ovf  <= 1'b0;
        p_res  <= '0;
      end else begin
        m_done <= 1'b0;
        if (m_left != 0) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_done <= 1'b1;
            m_sum  <= p_res[W-1:0];
            m_cout <= p_res[32];
            m_ovf  <= p_res[33];
          end
        end else if (bus.start) begin
          m_left <= W;
          p_res  <= ref_add(W, 32'(bus.a_in), 32'(bus.b_in), bus.cin);
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        checks++;
        if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !==
            {(m_left != 0), m_done, m_cout, m_ovf, m_sum}) begin
          errors++;
          $display("FAIL lane%0d W=%0d cycle: busy=%0b done=%0b cout=%0b ovf=%0b sum=%0h required busy=%0b done=%0b cout=%0b ovf=%0b sum=%0h at %0t",
                   g, W, bus.busy, bus.done, bus.cout, bus.ovf, bus.sum,
                   (m_left != 0), m_done, m_cout, m_ovf, m_sum, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic eco, input logic eov, input string nm);
    int n = 0;
    int bcnt = 0;
    bit seen = 1'b0;
    @(negedge clk);
    st0 = 1'b1; a0 = {24'h0, a}; b0 = {24'h0, b}; c0 = c;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        st0 = 1'b0; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; c0 = 1'b1;
      end
      if (d0_busy) bcnt++;
      if (d0_done) seen = 1'b1;
    end
    chk({nm, " done_latency"}, 64'(seen ? n : 99), 64'd9);
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'd8);
    chk({nm, " sum"}, 64'(d0_sum), 64'(es));
    chk({nm, " cout"}, 64'(d0_cout), 64'(eco));
    chk({nm, " ovf"}, 64'(d0_ovf), 64'(eov));
    @(negedge clk);
    chk({nm, " done_single"}, 64'(d0_done), 64'd0);
    chk({nm, " sum_hold"}, 64'(d0_sum), 64'(es));
  endtask

  task automatic back_to_back();
    logic [7:0] ta [3] = '{8'h12, 8'hC8, 8'h40};
    logic [7:0] tb [3] = '{8'h34, 8'h64, 8'h40};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h46, 8'h2D, 8'h80};
    logic       eco[3] = '{1'b0, 1'b1, 1'b0};
    logic       eov[3] = '{1'b0, 1'b0, 1'b1};
    int k;
    @(negedge clk);
    st0 = 1'b1; a0 = {24'h0, ta[0]}; b0 = {24'h0, tb[0]}; c0 = tc[0];
    for (int n = 1; n <= 27; n++) begin
      @(negedge clk);
      if (n % 9 == 0) begin
        k = n / 9 - 1;
        chk("b2b done", 64'(d0_done), 64'd1);
        chk("b2b sum", 64'(d0_sum), 64'(es[k]));
        chk("b2b cout", 64'(d0_cout), 64'(eco[k]));
        chk("b2b ovf", 64'(d0_ovf), 64'(eov[k]));
        if (k < 2) begin
          a0 = {24'h0, ta[k+1]}; b0 = {24'h0, tb[k+1]}; c0 = tc[k+1];
        end else begin
          st0 = 1'b0;
        end
      end else begin
        chk("b2b no_done", 64'(d0_done), 64'd0);
        a0 = $urandom; b0 = $urandom; c0 = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    st0 = 1'b1; a0 = 32'hAA; b0 = 32'h55; c0 = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      st0 = 1'b0;
    end
    #2 rst0 = 1'b0;
    #1;
    chk("rst_mid sum", 64'(d0_sum), 64'd0);
    chk("rst_mid cout_ovf", 64'({d0_cout, d0_ovf}), 64'd0);
    chk("rst_mid busy_done", 64'({d0_busy, d0_done}), 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_mid no_done", 64'(d0_done), 64'd0);
    end
    rst0 = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("post_rst no_done", 64'(d0_done), 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset sum", 64'(d0_sum), 64'd0);
    chk("reset flags", 64'({d0_busy, d0_done, d0_cout, d0_ovf}), 64'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    chk_en = 1'b1;

    fork
      begin
        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "add_5_3");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_1");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_1");
        run_op(8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0, "add_80_ff_1");
        back_to_back();
        reset_mid_run();
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst_1_1");
        for (int i = 0; i < 5000; i++) begin
          @(negedge clk);
          st0 = ($urandom_range(0, 2) != 0);
          a0 = $urandom; b0 = $urandom; c0 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        st0 = 1'b0;
      end
      begin
        for (int i = 0; i < 5000; i++) begin
          @(negedge clk);
          st1 = ($urandom_range(0, 2) != 0);
          a1 = $urandom; b1 = $urandom; c1 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        st1 = 1'b0;
      end
    join

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
